// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types for the fetch front end.
//   GHR_W         : global history width; equals the br_hist width in F2/D
//   bht_ctr_t     : 2-bit saturating direction counter
//   BHT_CTR_RESET : weakly not-taken
//   btb_entry_t   : {valid, tag, target[31:2]}
//   ctr_train     : saturating counter update
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int GHR_W = 2;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t BHT_CTR_RESET = 2'b01;

   // The tag field is sized for a single-entry BTB. Larger BTBs store
   // pc[31:2] >> BTB_IDX_BITS, which leaves the top bits zero.
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [29:0] target;
   } btb_entry_t;

   function automatic bht_ctr_t ctr_train(input bht_ctr_t ctr, input logic taken);
      bht_ctr_t res;
      res = ctr;
      if (taken && ctr != 2'b11)
         res = ctr + 2'b01;
      else if (!taken && ctr != 2'b00)
         res = ctr - 2'b01;
      return res;
   endfunction

endpackage

// File: rtl/fetch_stage1_branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB plus a gshare table of 2-bit counters.
//
// Lookup is combinational from the current arrays and GHR. Training is
// registered, so a lookup in the same cycle sees the old state.
//   clk, rst          : clock, synchronous active-high reset
//   lk_pc             : PC to predict
//   lk_hit            : BTB holds a valid entry for lk_pc
//   lk_target         : BTB target, word address [31:2]
//   lk_predict        : predicted taken (hit and counter MSB set)
//   lk_hist           : GHR used for this lookup
//   upd_*             : training from EX for a resolved conditional branch
// ---------------------------------------------------------------------------
module branch_predictor
   import fetch_pkg::*;
#(
   parameter int BHT_IDX_BITS = 6,
   parameter int BTB_IDX_BITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      lk_pc,
   output logic             lk_hit,
   output logic [29:0]      lk_target,
   output logic             lk_predict,
   output logic [GHR_W-1:0] lk_hist,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic [GHR_W-1:0] upd_br_hist
);

   localparam int BHT_N = 1 << BHT_IDX_BITS;
   localparam int BTB_N = 1 << BTB_IDX_BITS;

   bht_ctr_t         bht_q [BHT_N];
   btb_entry_t       btb_q [BTB_N];
   logic [GHR_W-1:0] ghr_q;

   // gshare: the history is folded into the low index bits only
   function automatic logic [BHT_IDX_BITS-1:0] bht_idx(input logic [31:0] pc,
                                                        input logic [GHR_W-1:0] h);
      return pc[BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(h);
   endfunction

   function automatic logic [BTB_IDX_BITS-1:0] btb_idx(input logic [31:0] pc);
      return pc[BTB_IDX_BITS+1:2];
   endfunction

   function automatic logic [29:0] btb_tag(input logic [31:0] pc);
      return pc[31:2] >> BTB_IDX_BITS;
   endfunction

   logic [BHT_IDX_BITS-1:0] lk_bidx;
   logic [BTB_IDX_BITS-1:0] lk_tidx;
   logic [BHT_IDX_BITS-1:0] upd_bidx;
   logic [BTB_IDX_BITS-1:0] upd_tidx;
   btb_entry_t              lk_entry;
   bht_ctr_t                lk_ctr;
   logic                    unused_bits;

   assign unused_bits = ^{lk_pc[1:0], upd_pc[1:0], upd_target[1:0]};

   // Lookup: combinational from lk_pc and current state
   assign lk_bidx    = bht_idx(lk_pc, ghr_q);
   assign lk_tidx    = btb_idx(lk_pc);
   assign lk_entry   = btb_q[lk_tidx];
   assign lk_ctr     = bht_q[lk_bidx];
   assign lk_hit     = lk_entry.valid && (lk_entry.tag == btb_tag(lk_pc));
   assign lk_target  = lk_entry.target;
   assign lk_predict = lk_hit && lk_ctr[1];
   assign lk_hist    = ghr_q;

   assign upd_bidx = bht_idx(upd_pc, upd_br_hist);
   assign upd_tidx = btb_idx(upd_pc);

   // Training: takes effect on the next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_q <= '0;
         for (int i = 0; i < BHT_N; i++)
            bht_q[i] <= BHT_CTR_RESET;
         for (int i = 0; i < BTB_N; i++)
            btb_q[i].valid <= 1'b0;
      end else if (upd_valid) begin
         ghr_q           <= {ghr_q[GHR_W-2:0], upd_taken};
         bht_q[upd_bidx] <= ctr_train(bht_q[upd_bidx], upd_taken);
         if (upd_taken) begin
            btb_q[upd_tidx].valid  <= 1'b1;
            btb_q[upd_tidx].tag    <= btb_tag(upd_pc);
            btb_q[upd_tidx].target <= upd_target[31:2];
         end
      end
   end

endmodule

// File: rtl/fetch_stage1.sv
// ---------------------------------------------------------------------------
// fetch_stage1
// First fetch stage. It holds the PC register and the next-PC mux and
// predicts every fetched PC through branch_predictor.
//   clk, rst        : clock, synchronous active-high reset
//   stall_pc        : hold the PC (shared with the F2 freeze)
//   mispredict      : load redirect_pc; this takes priority over stall_pc
//   redirect_pc     : correct next PC from EX; bits [1:0] ignored
//   upd_*           : predictor training from EX
//   imem_addr       : instruction-memory address (the PC register)
//   pc_F2           : PC fetched this cycle (the PC register)
//   predict_F2      : predicted taken for pc_F2
//   br_hist_F2      : GHR used for that prediction
// ---------------------------------------------------------------------------
module fetch_stage1
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          BHT_IDX_BITS = 6,
   parameter int          BTB_IDX_BITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_pc,
   input  logic             mispredict,
   input  logic [31:0]      redirect_pc,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic [GHR_W-1:0] upd_br_hist,
   output logic [31:0]      imem_addr,
   output logic [31:0]      pc_F2,
   output logic             predict_F2,
   output logic [GHR_W-1:0] br_hist_F2
);

   logic [31:0]      pc_q;
   logic [31:0]      pc_nxt;
   logic             bp_hit;
   logic [29:0]      bp_target;
   logic             bp_predict;
   logic [GHR_W-1:0] bp_hist;
   logic             unused_bits;

   assign unused_bits = ^{redirect_pc[1:0], bp_hit};

   branch_predictor #(
      .BHT_IDX_BITS(BHT_IDX_BITS),
      .BTB_IDX_BITS(BTB_IDX_BITS)
   ) u_bp (
      .clk        (clk),
      .rst        (rst),
      .lk_pc      (pc_q),
      .lk_hit     (bp_hit),
      .lk_target  (bp_target),
      .lk_predict (bp_predict),
      .lk_hist    (bp_hist),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_target (upd_target),
      .upd_br_hist(upd_br_hist)
   );

   // Next PC: redirect > stall > predicted target > sequential.
   // pc_q + 4 wraps naturally at 32 bits.
   always_comb begin
      pc_nxt = pc_q + 32'd4;
      if (mispredict)
         pc_nxt = {redirect_pc[31:2], 2'b00};
      else if (stall_pc)
         pc_nxt = pc_q;
      else if (bp_predict)
         pc_nxt = {bp_target, 2'b00};
   end

   // F1 -> F2 boundary: PC register
   always_ff @(posedge clk) begin
      if (rst)
         pc_q <= {RESET_PC[31:2], 2'b00};
      else
         pc_q <= pc_nxt;
   end

   assign imem_addr  = pc_q;
   assign pc_F2      = pc_q;
   assign predict_F2 = bp_predict;
   assign br_hist_F2 = bp_hist;

endmodule

// File: tb/tb_fetch_stage1.sv
module tb_fetch_stage1;

   logic        clk = 1'b0;
   logic        rst, stall_pc, mispredict, upd_valid, upd_taken;
   logic [31:0] redirect_pc, upd_pc, upd_target;
   logic [1:0]  upd_br_hist;
   logic [31:0] imem_addr, pc_F2;
   logic        predict_F2;
   logic [1:0]  br_hist_F2;

   always #5 clk = ~clk;

   fetch_stage1 #(
      .RESET_PC    (32'h0000_0000),
      .BHT_IDX_BITS(6),
      .BTB_IDX_BITS(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_pc   (stall_pc),
      .mispredict (mispredict),
      .redirect_pc(redirect_pc),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_target (upd_target),
      .upd_br_hist(upd_br_hist),
      .imem_addr  (imem_addr),
      .pc_F2      (pc_F2),
      .predict_F2 (predict_F2),
      .br_hist_F2 (br_hist_F2)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (spec-level) ----------------
   int unsigned m_pc;
   int unsigned m_ghr;
   int          m_ctr [64];
   bit          m_bv  [16];
   int unsigned m_btag[16];
   int unsigned m_btgt[16];
   bit          m_known = 0;

   function automatic void model_reset();
      m_pc  = 0;
      m_ghr = 0;
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      for (int i = 0; i < 16; i++) m_bv[i] = 0;
   endfunction

   function automatic bit model_predict(output int unsigned tgt);
      int unsigned bi, ci;
      bi  = (m_pc / 4) % 16;
      ci  = ((m_pc / 4) % 64) ^ m_ghr;
      tgt = m_btgt[bi];
      return m_bv[bi] && (m_btag[bi] == m_pc / 64) && (m_ctr[ci] >= 2);
   endfunction

   function automatic void model_step(input bit r, st, mp, input int unsigned rpc,
                                      input bit uv, input int unsigned upc, input bit ut,
                                      input int unsigned utg, input int unsigned uh);
      int unsigned tgt, ci, bi;
      bit pred;
      if (r) begin
         model_reset();
         return;
      end
      pred = model_predict(tgt);
      if (uv) begin
         ci = ((upc / 4) % 64) ^ uh;
         if (ut) m_ctr[ci] = (m_ctr[ci] == 3) ? 3 : m_ctr[ci] + 1;
         else    m_ctr[ci] = (m_ctr[ci] == 0) ? 0 : m_ctr[ci] - 1;
         m_ghr = ((m_ghr * 2) + (ut ? 1 : 0)) % 4;
         if (ut) begin
            bi = (upc / 4) % 16;
            m_bv[bi]   = 1;
            m_btag[bi] = upc / 64;
            m_btgt[bi] = utg & 32'hFFFF_FFFC;
         end
      end
      if (mp)        m_pc = rpc & 32'hFFFF_FFFC;
      else if (st)   m_pc = m_pc;
      else if (pred) m_pc = tgt;
      else           m_pc = m_pc + 4;  // 32-bit unsigned wrap
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] pc;
      logic        pred;
      logic [1:0]  hist;
   } exp_t;
   exp_t sb[$];

   task automatic cyc(input bit r, st, mp, input logic [31:0] rpc,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utg, input logic [1:0] uh);
      exp_t e;
      int unsigned t;
      @(posedge clk);
      #1;
      rst = r; stall_pc = st; mispredict = mp; redirect_pc = rpc;
      upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg; upd_br_hist = uh;
      if (m_known) begin
         e.pc   = m_pc;
         e.pred = model_predict(t);
         e.hist = 2'(m_ghr);
         sb.push_back(e);
      end
      model_step(r, st, mp, rpc, uv, upc, ut, utg, uh);
   endtask

   task automatic idle(input bit st);
      cyc(0, st, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic redir(input logic [31:0] rpc);
      cyc(0, 0, 1, rpc, 0, 0, 0, 0, 0);
   endtask

   task automatic upd(input bit st, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utg, input logic [1:0] uh);
      cyc(0, st, 0, 0, 1, upc, ut, utg, uh);
   endtask

   // Monitor: the DUT presents a fetch every cycle; compare mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("sb_pc_F2",      pc_F2,      e.pc);
         chk("sb_imem_addr",  imem_addr,  e.pc);
         chk("sb_predict_F2", 32'(predict_F2), 32'(e.pred));
         chk("sb_br_hist_F2", 32'(br_hist_F2), 32'(e.hist));
      end
   end

   initial begin
      rst = 1; stall_pc = 0; mispredict = 0; redirect_pc = 0;
      upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_br_hist = 0;
      @(posedge clk);
      model_reset();
      m_known = 1;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // free run, stall, redirect overriding stall
      idle(0); #2 chk("run_pc0", pc_F2, 32'h0); chk("run_pred0", 32'(predict_F2), 0);
      chk("run_hist0", 32'(br_hist_F2), 0);
      idle(0); #2 chk("run_pc4", pc_F2, 32'h4);
      idle(1); #2 chk("stall_pc8a", pc_F2, 32'h8);
      idle(1); #2 chk("stall_pc8b", pc_F2, 32'h8);
      idle(0); #2 chk("stall_pc8c", pc_F2, 32'h8);
      idle(0); #2 chk("after_stall_pcC", pc_F2, 32'hC);
      cyc(0, 1, 1, 32'h203, 0, 0, 0, 0, 0); #2 chk("wrongpath_pc10", pc_F2, 32'h10);
      idle(0); #2 chk("redirect_pc200", pc_F2, 32'h200);

      // training then redirect onto the trained branch
      upd(0, 32'h40, 1, 32'h100, 2'b00);
      upd(0, 32'h80, 0, 32'h0, 2'b00);
      upd(0, 32'h80, 0, 32'h0, 2'b00);
      redir(32'h40);
      idle(0); #2 chk("train_pc40", pc_F2, 32'h40); chk("train_pred", 32'(predict_F2), 1);
      chk("train_hist", 32'(br_hist_F2), 0);
      idle(0); #2 chk("train_tgt100", pc_F2, 32'h100);

      // same-cycle update on the looked-up entry
      cyc(0, 0, 1, 32'h500, 1, 32'h700, 1, 32'h704, 2'b00);
      upd(1, 32'h700, 1, 32'h704, 2'b00);
      upd(1, 32'h500, 1, 32'h600, 2'b11); #2 chk("same_cyc_old", 32'(predict_F2), 0);
      idle(1); #2 chk("same_cyc_new", 32'(predict_F2), 1);
      idle(0); #2 chk("same_cyc_pc", pc_F2, 32'h500);
      idle(0); #2 chk("same_cyc_tgt", pc_F2, 32'h600);

      // saturation at one index, observed by redirecting onto it
      for (int i = 0; i < 5; i++) upd(0, 32'h800, 1, 32'h900, 2'b00);
      upd(0, 32'h800, 0, 0, 2'b00);
      upd(0, 32'h8C0, 0, 0, 2'b00);  // other index: brings GHR to 00
      redir(32'h800);
      idle(1); #2 chk("sat_still_taken", 32'(predict_F2), 1);
      for (int i = 0; i < 4; i++) upd(1, 32'h800, 0, 0, 2'b00);
      idle(1); #2 chk("sat_floor", 32'(predict_F2), 0);
      upd(1, 32'h800, 1, 32'h900, 2'b00);
      idle(1);

      // wraparound
      redir(32'hFFFF_FFFC);
      idle(0); #2 chk("wrap_top", pc_F2, 32'hFFFF_FFFC);
      idle(0); #2 chk("wrap_zero", pc_F2, 32'h0);

      // reset together with redirect and update
      cyc(1, 0, 1, 32'h40, 1, 32'h44, 1, 32'h300, 2'b01);
      idle(0); #2 chk("rst_pc", pc_F2, 32'h0); chk("rst_pred", 32'(predict_F2), 0);
      chk("rst_hist", 32'(br_hist_F2), 0);
      redir(32'h40);
      idle(0); #2 chk("rst_btb_clear", 32'(predict_F2), 0);

      // randomized traffic over a small PC window to get frequent hits
      for (int n = 0; n < 800; n++) begin
         bit r, st, mp, uv, ut;
         logic [31:0] rpc, upc, utg;
         logic [1:0] uh;
         r   = ($urandom_range(0, 199) == 0);
         st  = ($urandom_range(0, 4) == 0);
         mp  = ($urandom_range(0, 9) == 0);
         uv  = ($urandom_range(0, 2) == 0);
         ut  = $urandom_range(0, 1);
         rpc = $urandom_range(0, 32'h1FF);
         upc = $urandom_range(0, 32'h1FF) & 32'h1FC;
         utg = $urandom_range(0, 32'h1FF);
         uh  = 2'($urandom_range(0, 3));
         cyc(r, st, mp, rpc, uv, upc, ut, utg, uh);
      end

      idle(0);
      @(negedge clk);
      #1;
      chk("sb_drain", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
